pwm_demod: RTL and testbench

PWM_DEMOD -- requirements
Module: pwm_demod

---
 rtl/pwm_pkg.sv | 26 ++
 rtl/pwm_in_sync.sv | 42 ++++
 rtl/pwm_demod.sv | 124 ++++++++++++
 tb/tb_pwm_demod.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the PWM demodulator and the matching
// transmitter: the receive FSM state encoding and the period/offset derivation.
package pwm_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,  // waiting for a genuine rising edge
    HIGH = 2'd1,  // measuring the high phase
    LOW  = 2'd2   // measuring the low phase
  } pwm_state_e;

  localparam int PWM_COUNT_WIDTH = 10;

  // One PWM period in clocks.
  function automatic int pwm_period(input int count_width);
    return 1 << count_width;
  endfunction

  // Bias that maps a mid-scale duty cycle to sample value 0.
  function automatic int pwm_offset(input int count_width);
    return 1 << (count_width - 1);
  endfunction

  localparam int PWM_PERIOD = pwm_period(PWM_COUNT_WIDTH);
  localparam int PWM_OFFSET = pwm_offset(PWM_COUNT_WIDTH);

endpackage

// File: rtl/pwm_in_sync.sv
// pwm_in_sync: two-flop synchronizer for the asynchronous PWM input, followed
// by a delay stage and a registered rising-edge detector.
//   clk  : clock
//   rst  : synchronous active-high reset
//   din  : asynchronous PWM input
//   dout : synchronized level, aligned with rise
//   rise : one-cycle pulse on a 0->1 transition of the synchronized level
module pwm_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);
  import pwm_pkg::*;

  localparam int STAGES = 2;

  logic s1, s2, s2_d;
  // vld_pipe[k] marks that stage k holds a real sample rather than a reset
  // value; a reset zero followed by a steady-high input is not an edge.
  logic [STAGES:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s2_d     <= 1'b0;
      rise     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      s1       <= din;
      s2       <= s1;
      s2_d     <= s2;
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      rise     <= s2 & ~s2_d & vld_pipe[STAGES];
    end
  end

  assign dout = s2_d;

endmodule

// File: rtl/pwm_demod.sv
// pwm_demod: recovers a two's-complement sample from a PWM stream by timing
// the high and low phases of each period.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   pwm_in     : asynchronous PWM stream
//   data_out   : recovered sample (high width - 1 - OFFSET)
//   data_valid : one-cycle strobe for a new data_out
//   locked     : high while well-formed periods are arriving
//   period_err : one-cycle strobe for a period whose length is not PERIOD
module pwm_demod #(
  parameter int DATA_WIDTH  = 12,
  parameter int COUNT_WIDTH = pwm_pkg::PWM_COUNT_WIDTH,
  parameter int OFFSET      = pwm_pkg::PWM_OFFSET
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pwm_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  locked,
  output logic                  period_err
);
  import pwm_pkg::*;

  localparam int CW = COUNT_WIDTH + 1;
  localparam int AW = (DATA_WIDTH > COUNT_WIDTH + 2) ? DATA_WIDTH : COUNT_WIDTH + 2;
  localparam logic [CW-1:0] PERIOD_C = CW'(pwm_period(COUNT_WIDTH));

  pwm_state_e            state;
  logic                  pwm_s, rise;
  logic [CW-1:0]         high_cnt, low_cnt, high_nxt, low_nxt, meas;
  logic [CW:0]           period_len;
  logic signed [AW-1:0]  meas_ext;
  logic [DATA_WIDTH-1:0] sample;

  pwm_in_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pwm_in),
    .dout (pwm_s),
    .rise (rise)
  );

  // Saturating increments.
  assign high_nxt   = (high_cnt == PERIOD_C) ? high_cnt : high_cnt + CW'(1);
  assign low_nxt    = (low_cnt  == PERIOD_C) ? low_cnt  : low_cnt  + CW'(1);
  assign period_len = {1'b0, high_cnt} + {1'b0, low_cnt};

  // A rise in LOW measures the finished high phase; a stuck-high emission
  // happens in HIGH on the cycle the count would reach PERIOD.
  assign meas     = (state == HIGH) ? high_nxt : high_cnt;
  assign meas_ext = $signed(AW'(meas));
  assign sample   = DATA_WIDTH'(meas_ext - $signed(AW'(OFFSET + 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SYNC;
      high_cnt   <= '0;
      low_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
      period_err <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      period_err <= 1'b0;
      if (rise) begin
        // The rise cycle is the first high clock of the new period.
        high_cnt <= CW'(1);
        low_cnt  <= '0;
        state    <= HIGH;
        if (state == LOW) begin
          if (period_len == {1'b0, PERIOD_C}) begin
            data_out   <= sample;
            data_valid <= 1'b1;
            locked     <= 1'b1;
          end else begin
            period_err <= 1'b1;
            locked     <= 1'b0;
          end
        end
      end else begin
        case (state)
          SYNC: begin
            // low_cnt doubles as the no-edge timeout while hunting.
            low_cnt <= low_nxt;
            if (low_nxt == PERIOD_C) locked <= 1'b0;
          end
          HIGH: begin
            if (pwm_s) begin
              if (high_nxt == PERIOD_C) begin
                // Full-scale duty: emit once per PERIOD and restart the count
                // so a later falling edge still measures a whole period.
                data_out   <= sample;
                data_valid <= 1'b1;
                locked     <= 1'b1;
                high_cnt   <= '0;
              end else begin
                high_cnt <= high_nxt;
              end
            end else begin
              // The falling-edge cycle is the first low clock.
              state   <= LOW;
              low_cnt <= low_nxt;
            end
          end
          LOW: begin
            if (!pwm_s) begin
              if (low_nxt == PERIOD_C) begin
                state   <= SYNC;
                locked  <= 1'b0;
                low_cnt <= '0;
              end else begin
                low_cnt <= low_nxt;
              end
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_demod.sv
module tb_pwm_demod;
  import pwm_pkg::*;

  localparam int K_NONE = 0;
  localparam int K_VAL  = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    logic        err;
    logic [11:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm_in;
  logic [11:0] data_out;
  logic        data_valid, locked, period_err;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_rise = 0;
  int   drop = -1;
  exp_t sb[$];
  exp_t e;

  pwm_demod dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .locked     (locked),
    .period_err (period_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One transmitter period: high for 'high' clocks out of 'len'. The
  // expectation pushed at its start is what the DUT must report 'lat' clocks
  // later (the closing of the previous period, or a stuck-high emission).
  task automatic send_period(input int high, input int len, input int kind,
                             input logic [11:0] d, input int lat, input int rst_at);
    exp_t x;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0 && kind != K_NONE) begin
        x.err  = (kind == K_ERR);
        x.data = d;
        x.cyc  = cyc + lat;
        sb.push_back(x);
      end
      if (i == rst_at) rst = 1'b1;
      if (rst_at >= 0 && i == rst_at + 1) begin
        rst = 1'b0;
        chk("rst_data_out", data_out, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_period_err", period_err, 0);
        chk("rst_state", dut.state, SYNC);
      end
      if (i == 0 && high > 0 && pwm_in == 1'b0) last_rise = cyc;
      pwm_in = (i < high);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (data_valid || period_err) begin
      chk("valid_err_exclusive", data_valid & period_err, 0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got valid=%0d err=%0d data=%0h expected none (cycle %0d)",
                 data_valid, period_err, data_out, cyc);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind_err", period_err, e.err);
        chk("strobe_cycle", cyc, e.cyc);
        chk("strobe_data", data_out, e.data);
        chk("strobe_locked", locked, !e.err);
      end
    end
  end

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_data_out", data_out, 0);
    chk("reset_valid", data_valid, 0);
    chk("reset_locked", locked, 0);
    chk("reset_period_err", period_err, 0);
    chk("reset_state", dut.state, SYNC);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // data_in = 0: high 513 of 1024 -> sample 0; lock on the second rise.
    send_period(513, 1024, K_NONE, 12'h000, 4, -1);
    chk("unlocked_after_first_rise", locked, 0);
    send_period(513, 1024, K_VAL, 12'h000, 4, -1);
    send_period(513, 1024, K_VAL, 12'h000, 4, -1);
    send_period(513, 1024, K_VAL, 12'h000, 4, -1);

    // data_in = -512: high width 1 -> 0xE00.
    send_period(1, 1024, K_VAL, 12'h000, 4, -1);
    send_period(1, 1024, K_VAL, 12'hE00, 4, -1);
    send_period(1, 1024, K_VAL, 12'hE00, 4, -1);

    // Stuck low for 1100 clocks: lock drops within 1024 clocks of the last
    // rise plus the 4-clock input pipeline, without any strobe.
    chk("locked_before_stuck_low", locked, 1);
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      pwm_in = 1'b0;
      if (drop < 0 && !locked) drop = cyc;
    end
    chk("lock_dropped", drop >= 0, 1);
    chk("lock_drop_in_time", (drop - last_rise) <= 1028, 1);
    chk("stuck_low_state", dut.state, SYNC);

    // Reacquire with high 600 (-> 87), then a 1000-clock period.
    send_period(600, 1024, K_NONE, 12'h000, 4, -1);
    send_period(600, 1024, K_VAL, 12'h057, 4, -1);
    send_period(600, 1000, K_VAL, 12'h057, 4, -1);
    send_period(600, 1024, K_ERR, 12'h057, 4, -1);   // data_out holds
    send_period(100, 1024, K_VAL, 12'h057, 4, -1);   // recovery
    send_period(100, 1024, K_VAL, 12'hE63, 4, -1);   // 100-1-512 = -413

    // data_in = 511: constant high -> 511 every 1024 clocks.
    send_period(1024, 1024, K_VAL, 12'hE63, 4, -1);
    send_period(1024, 1024, K_VAL, 12'h1FF, 3, -1);
    send_period(1024, 1024, K_VAL, 12'h1FF, 3, -1);
    send_period(513,  1024, K_VAL, 12'h1FF, 3, -1);

    // Reset mid-HIGH; first sample only after a full later period.
    send_period(513, 1024, K_VAL, 12'h000, 4, 200);
    send_period(513, 1024, K_NONE, 12'h000, 4, -1);
    send_period(513, 1024, K_VAL, 12'h000, 4, -1);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pwm_in = 1'b0;
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
